// File: rtl/neuron_sequencer.sv
// neuron_sequencer: drives one neuron evaluation. It clears the MAC and loads
// the bias, streams N_INPUTS pixel/weight products from a shared memory with a
// one-cycle read latency, then requantizes the 16-bit accumulator to 8 bits and
// offers the result on a valid/ready handshake.
module neuron_sequencer #(
  parameter int N_INPUTS = 784,
  parameter int ADDR_W   = 10,
  parameter int SHIFT    = 7
) (
  input  logic              clkext,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  input  logic [7:0]        pixel,
  input  logic [7:0]        weight,
  input  logic [7:0]        bias,
  output logic              mac_rst,
  output logic              mac_en,
  output logic [7:0]        mac_a,
  output logic [7:0]        mac_b,
  output logic [7:0]        mac_bias,
  input  logic [15:0]       mac_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_BIAS,
    S_ACCUM,
    S_DRAIN,
    S_CAPTURE,
    S_OUTPUT
  } state_t;

  // Address of the last product; the counter stops here and never wraps.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_INPUTS - 1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_next;
  logic [7:0]        data_q;
  logic [7:0]        data_next;
  logic [15:0]       shifted;
  logic [7:0]        saturated;

  // Requantize: logical shift of the (possibly wrapped) accumulator, then
  // unsigned saturation to 8 bits.
  assign shifted   = mac_result >> SHIFT;
  assign saturated = (shifted > 16'd255) ? 8'hFF : shifted[7:0];

  // State register, read-address counter and result register.
  always_ff @(posedge clkext) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state  <= S_IDLE;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state  <= state_next;
      addr_q <= addr_next;
      data_q <= data_next;
    end
  end

  // Next-state logic; the address returns to 0 whenever ACCUM is not next.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    state_next = state;
    addr_next  = '0;
    data_next  = data_q;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_LOAD_BIAS;
      end
      S_LOAD_BIAS: begin
        // Address 0 is issued here, so ACCUM starts at address 1.
        if (N_INPUTS > 1) begin
          state_next = S_ACCUM;
          addr_next  = ADDR_W'(1);
        end else begin
          state_next = S_DRAIN;
        end
      end
      S_ACCUM: begin
        if (addr_q == LAST_ADDR) state_next = S_DRAIN;
        else                     addr_next  = addr_q + ADDR_W'(1);
      end
      S_DRAIN: begin
        state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        data_next  = saturated;
        state_next = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (out_ready) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Outputs; while rst is high they are forced to their idle values within
  // the same cycle, before the synchronous reset has taken effect.
  always_comb begin
    busy      = 1'b0;
    addr      = '0;
    mac_rst   = 1'b1;
    mac_en    = 1'b0;
    mac_a     = '0;
    mac_b     = '0;
    mac_bias  = '0;
    out_valid = 1'b0;
    out_data  = '0;
    if (!rst) begin
      busy      = (state != S_IDLE);
      addr      = addr_q;
      mac_rst   = (state == S_LOAD_BIAS);
      mac_en    = (state == S_ACCUM) || (state == S_DRAIN);
      out_valid = (state == S_OUTPUT);
      out_data  = data_q;
      if (mac_en) begin
        mac_a = pixel;
        mac_b = weight;
      end
      if (state == S_LOAD_BIAS) mac_bias = bias;
    end
  end

endmodule

// File: tb/tb_neuron_sequencer.sv
// tb_neuron_sequencer: scoreboard bench. Stimulus pushes the expected result
// of each evaluation into a queue; a monitor pops and compares on every
// output handshake. The memories and the MAC are modelled around the DUT.
module tb_neuron_sequencer;

  localparam int N  = 4;
  localparam int SH = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (N=4, SHIFT=0)
  logic        rst, start, out_ready;
  logic [7:0]  pixel, weight, bias;
  logic        busy, mac_rst, mac_en, out_valid;
  logic [9:0]  addr;
  logic [7:0]  mac_a, mac_b, mac_bias, out_data;
  logic [15:0] acc;

  // Two single-input DUTs (SHIFT=8 and SHIFT=0) sharing one stimulus
  logic        start1;
  logic [7:0]  px1 = 8'd255, wt1 = 8'd255, bias1 = 8'd0;
  logic        out_ready1 = 1'b1;
  logic        busy_s8, mac_rst_s8, mac_en_s8, out_valid_s8;
  logic        busy_s0, mac_rst_s0, mac_en_s0, out_valid_s0;
  logic [1:0]  addr_s8, addr_s0;
  logic [7:0]  mac_a_s8, mac_b_s8, mac_bias_s8, out_data_s8;
  logic [7:0]  mac_a_s0, mac_b_s0, mac_bias_s0, out_data_s0;
  logic [15:0] acc_s8, acc_s0;

  logic [7:0]  pix_mem [0:N-1];
  logic [7:0]  wt_mem  [0:N-1];

  logic [7:0]  exp_q [$];
  int          valid_times [$];
  int          n_checks = 0;
  int          n_err    = 0;
  int          n_out    = 0;
  int          cyc      = 0;
  int          en_cnt   = 0;

  neuron_sequencer #(.N_INPUTS(N), .ADDR_W(10), .SHIFT(SH)) u_dut (
    .clkext(clk), .rst(rst), .start(start), .busy(busy), .addr(addr),
    .pixel(pixel), .weight(weight), .bias(bias),
    .mac_rst(mac_rst), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
    .mac_bias(mac_bias), .mac_result(acc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  neuron_sequencer #(.N_INPUTS(1), .ADDR_W(2), .SHIFT(8)) u_one_s8 (
    .clkext(clk), .rst(rst), .start(start1), .busy(busy_s8), .addr(addr_s8),
    .pixel(px1), .weight(wt1), .bias(bias1),
    .mac_rst(mac_rst_s8), .mac_en(mac_en_s8), .mac_a(mac_a_s8), .mac_b(mac_b_s8),
    .mac_bias(mac_bias_s8), .mac_result(acc_s8),
    .out_valid(out_valid_s8), .out_ready(out_ready1), .out_data(out_data_s8)
  );

  neuron_sequencer #(.N_INPUTS(1), .ADDR_W(2), .SHIFT(0)) u_one_s0 (
    .clkext(clk), .rst(rst), .start(start1), .busy(busy_s0), .addr(addr_s0),
    .pixel(px1), .weight(wt1), .bias(bias1),
    .mac_rst(mac_rst_s0), .mac_en(mac_en_s0), .mac_a(mac_a_s0), .mac_b(mac_b_s0),
    .mac_bias(mac_bias_s0), .mac_result(acc_s0),
    .out_valid(out_valid_s0), .out_ready(out_ready1), .out_data(out_data_s0)
  );

  // Synchronous-read memories: data appears one cycle after the address.
  always @(posedge clk) begin
    pixel  <= (int'(addr) < N) ? pix_mem[addr[1:0]] : 8'hxx;
    weight <= (int'(addr) < N) ? wt_mem[addr[1:0]]  : 8'hxx;
  end

  // Registered 16-bit MAC accumulators with clear/bias-load.
  always @(posedge clk) begin
    if (mac_rst)     acc <= {8'd0, mac_bias};
    else if (mac_en) acc <= acc + 16'(mac_a) * 16'(mac_b);
    if (mac_rst_s8)     acc_s8 <= {8'd0, mac_bias_s8};
    else if (mac_en_s8) acc_s8 <= acc_s8 + 16'(mac_a_s8) * 16'(mac_b_s8);
    if (mac_rst_s0)     acc_s0 <= {8'd0, mac_bias_s0};
    else if (mac_en_s0) acc_s0 <= acc_s0 + 16'(mac_a_s0) * 16'(mac_b_s0);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // Reference: bias plus dot product, wrapped to 16 bits, shifted, saturated.
  function automatic logic [7:0] ref_requant(input int unsigned total, input int shift);
    int unsigned w;
    w = (total % 65536) >> shift;
    return (w > 255) ? 8'd255 : 8'(w);
  endfunction

  function automatic logic [7:0] expected_main();
    int unsigned s;
    s = int'(bias);
    for (int i = 0; i < N; i++) s += int'(pix_mem[i]) * int'(wt_mem[i]);
    return ref_requant(s, SH);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_basic();
    pix_mem = '{8'd1, 8'd2, 8'd3, 8'd4};
    wt_mem  = '{8'd1, 8'd1, 8'd1, 8'd1};
    bias    = 8'd5;
  endtask

  task automatic wait_valid(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) check(name, out_valid, 1'b1);
  endtask

  // Monitor: compares every handshake against the scoreboard queue and
  // counts MAC-enable cycles per evaluation.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        en_cnt = 0;
      end else begin
        if (mac_en) en_cnt++;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", out_valid, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e);
          end
          check("mac_en_cycles", en_cnt, N);
          en_cnt = 0;
          valid_times.push_back(cyc);
          n_out++;
        end
      end
    end
  end

  // Known vector: sum 15, address order 0..3, OUT_VALID only in cycle 7.
  task automatic basic_run(input string tag);
    load_basic();
    exp_q.push_back(8'd15);
    start = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k >= 1 && k <= 4) check({tag, "_addr"}, addr, k - 1);
      check({tag, "_valid"}, out_valid, k == 7);
      check({tag, "_busy"}, busy, k >= 1 && k <= 7);
      check({tag, "_mac_en"}, mac_en, k >= 2 && k <= 5);
      tick();
      if (k == 0) start = 1'b0;
    end
  endtask

  // One evaluation with a random back-pressure delay on OUT_READY.
  task automatic run_eval(input logic [7:0] e);
    exp_q.push_back(e);
    out_ready = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    wait_valid("eval_timeout");
    tick();
    repeat ($urandom_range(0, 3)) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int base, tq, seen, k, mode;
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, tq, seen, k, mode;
    rst = 1'b1; start = 1'b1; out_ready = 1'b0; start1 = 1'b0;
    load_basic();
    bias = 8'd77;
    repeat (3) @(posedge clk);
    #1;

    // Reset state (START and BIAS driven to show they are masked)
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_addr", addr, 0);
    check("rst_mac_en", mac_en, 1'b0);
    check("rst_mac_rst", mac_rst, 1'b1);
    check("rst_mac_a", mac_a, 0);
    check("rst_mac_b", mac_b, 0);
    check("rst_mac_bias", mac_bias, 0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 0);
    tick();
    rst = 1'b0; start = 1'b0; out_ready = 1'b1;

    // First START after reset, known vector
    basic_run("basic");

    // Single-input evaluations: 255*255 with SHIFT=8 and saturated SHIFT=0
    start1 = 1'b1;
    for (int j = 0; j <= 5; j++) begin
      @(negedge clk);
      check("n1_valid_s8", out_valid_s8, j == 4);
      check("n1_valid_s0", out_valid_s0, j == 4);
      check("n1_mac_en", mac_en_s8, j == 2);
      check("n1_busy_s8", busy_s8, j >= 1 && j <= 4);
      check("n1_busy_s0", busy_s0, j >= 1 && j <= 4);
      if (j == 1) check("n1_addr", addr_s8 | addr_s0, 0);
      if (j == 4) begin
        check("n1_data_s8", out_data_s8, ref_requant(255 * 255, 8));
        check("n1_data_s0", out_data_s0, ref_requant(255 * 255, 0));
      end
      tick();
      if (j == 0) start1 = 1'b0;
    end

    // OUTPUT held by OUT_READY=0 for 5 cycles, START pulsed meanwhile
    load_basic();
    exp_q.push_back(8'd15);
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid("hold_timeout");
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_busy", busy, 1'b1);
      check("hold_data", out_data, 15);
      tick();
      start = (i == 1);
      @(negedge clk);
    end
    tick();
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("hold_valid_last", out_valid, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_idle", busy, 1'b0);
      tick();
    end

    // Reset on the 3rd ACCUM cycle aborts the evaluation
    load_basic();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_mac_en", mac_en, 1'b0);
    check("abort_mac_rst", mac_rst, 1'b1);
    check("abort_addr", addr, 0);
    check("abort_out_data", out_data, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort_idle_busy", busy, 1'b0);
    check("abort_idle_mac_en", mac_en, 1'b0);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_valid", seen, 0);
    tick();
    basic_run("rerun");

    // Accumulator wrap: 65025 + 510 + 101 = 65636 -> 100
    pix_mem = '{8'd255, 8'd2, 8'd0, 8'd0};
    wt_mem  = '{8'd255, 8'd255, 8'd0, 8'd0};
    bias    = 8'd101;
    run_eval(expected_main());

    // Random evaluations: small operands, full-range, and mixed
    for (int e = 0; e < 25; e++) begin
      mode = $urandom_range(0, 2);
      for (int i = 0; i < N; i++) begin
        pix_mem[i] = (mode == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
        wt_mem[i]  = (mode == 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
      end
      bias = (mode == 0) ? 8'($urandom_range(0, 63)) : 8'($urandom_range(0, 255));
      run_eval(expected_main());
    end

    // START held high: back-to-back evaluations 8 cycles apart
    load_basic();
    out_ready = 1'b1;
    base = n_out;
    tq   = valid_times.size();
    repeat (3) exp_q.push_back(8'd15);
    start = 1'b1;
    k = 0;
    while (n_out < base + 3 && k < 100) begin
      tick();
      k++;
    end
    start = 1'b0;
    if (n_out < base + 3) check("b2b_timeout", n_out, base + 3);
    if (valid_times.size() >= tq + 3) begin
      check("b2b_gap1", valid_times[tq + 1] - valid_times[tq], 8);
      check("b2b_gap2", valid_times[tq + 2] - valid_times[tq + 1], 8);
    end
    repeat (12) tick();
    @(negedge clk);
    check("final_idle", busy, 1'b0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
